adc_sample_packer: RTL and testbench
====================================

# adc_sample_packer

Capture stage directly downstream of the ADC emulator. Latches the emulator's sample bus on every strobe pulse and packs PACK consecutive samples into one wide word. Buffers packed words in a first-word-fall-through FIFO and presents them to the DMA write engine over a valid/ready stream, with a frame-end marker every FRAME_WORDS words. Flags and counts words lost to back-pressure.

## Interface
Parameters:
- WIDTH, 16, sample width in bits; must equal the emulator sample width.
- PACK, 2, samples per output word; allowed values 2 or 4.
- DEPTH, 16, FIFO depth in words; power of 2, at least 4.
- FRAME_WORDS, 256, words per frame; m_last is tagged on the last word of each frame; at least 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  capture enable.
- sample  in  WIDTH  sample bus from the emulator; sampled only when strobe=1.
- strobe  in  1  one-cycle sample-valid pulse; may be high on consecutive cycles.
- m_data  out  WIDTH*PACK  packed word; lane 0, the oldest sample, sits in bits [WIDTH-1:0].
- m_valid  out  1  FIFO head is valid.
- m_ready  in  1  consumer accepts the head.
- m_last  out  1  head word is the last word of its frame.
- overflow  out  1  sticky flag: at least one word was dropped.
- drop_count  out  16  number of dropped words; saturates at 16'hFFFF.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, range 0..DEPTH.

## Operation
- **Capture:** on an edge with strobe=1 and enable=1, the sample goes into lane lane_idx, then lane_idx advances.
  - On the edge that fills lane PACK-1, the word is assembled from the held lanes plus the current sample and pushed into the FIFO on that same edge.
  - lane_idx then returns to 0.
- **Enable low:** on any edge with enable=0:
  - lane_idx is cleared and any partial word is discarded;
  - the frame word counter is cleared to 0;
  - strobes are ignored;
  - the FIFO keeps draining normally.
- **Push accept rule:** a completed word is written when level<DEPTH, or when level==DEPTH and a pop happens on the same edge (m_valid & m_ready).
  - Otherwise the word is dropped: overflow is set to 1 and drop_count increments, saturating at 16'hFFFF.
  - overflow and drop_count are cleared only by reset.
- **Frame counter:** advances only on accepted words.
  - When the counter equals FRAME_WORDS-1, the word is stored with last=1 and the counter wraps to 0.
  - Dropped words do not advance the counter.
- **FIFO:** first-word-fall-through. Each entry holds {last, data}. Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - Pop occurs on an edge with m_valid & m_ready.
  - Simultaneous push and pop leaves level unchanged.
- **Stream rule:** while m_valid=1 and m_ready=0, m_data and m_last hold stable. m_ready while m_valid=0 has no effect.
- **Reset** (asynchronous assert, synchronous release):
  - m_valid, m_last, overflow = 0; drop_count = 0; level = 0; m_data = 0;
  - lane_idx = 0 and frame counter = 0;
  - FIFO empty.

  Asserting reset mid-word or mid-frame discards all buffered data.

## Timing
- Latency: completing strobe at edge N gives m_valid=1 after edge N when the FIFO was empty. The word is poppable at edge N+1.
- Sustained throughput: one strobe per cycle with m_ready held at 1 is lossless. The FIFO never exceeds 1 entry.
- level, overflow and drop_count update on the same edge as the push or pop that changes them.
- m_valid is a registered function of the pointers. No combinational path exists from m_ready to m_valid.
- Each strobe cycle is sampled exactly once. There is no edge detection on strobe.

## Test plan
- **Reset values:** hold reset=0 and toggle clk and strobe → all outputs 0 and level=0. Release reset → outputs remain 0 until a completed word.
- **Packing (PACK=2):** strobes with samples 16'h0001, then 16'h0002, m_ready=1 → one word 32'h0002_0001, m_valid high the cycle after the 2nd strobe edge, level returns to 0.
- **Back-pressure and overflow (DEPTH=16, PACK=2):** m_ready=0, 34 strobes → level=16, overflow=1, drop_count=1. Then assert m_ready → exactly 16 words in order, first 32'h0002_0001 for samples 1..32.
- **Full with simultaneous pop:** level=16, completing strobe on the same edge as a pop → word accepted, level stays 16, overflow stays 0.
- **Frame marker (FRAME_WORDS=4):** 10 words accepted → m_last=1 on words 4 and 8 only. Deassert enable for 1 cycle, then restart → m_last is next on the 4th new word.
- **Partial discard:** strobe with sample 16'hAAAA, then enable=0 for 1 cycle, then strobes with 16'h0003 and 16'h0004 → single word 32'h0004_0003; 16'hAAAA never appears.

Source files
------------

// File: rtl/adc_sample_packer.sv
// adc_sample_packer
// Packs PACK consecutive ADC samples (oldest in lane 0) into one wide word,
// buffers the words in a first-word-fall-through FIFO and streams them out
// with valid/ready. A frame-end marker rides with every FRAME_WORDS-th
// accepted word. Words that find the FIFO full are dropped and counted.
module adc_sample_packer #(
    parameter int WIDTH       = 16,
    parameter int PACK        = 2,
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          sample,
    input  logic                      strobe,
    output logic [WIDTH*PACK-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(PACK);
    localparam int FW = $clog2(FRAME_WORDS);
    localparam int DW = WIDTH * PACK;

    // Capture state: lanes 0..PACK-2 are held, the top lane is the live sample.
    logic [IW-1:0]    lane_idx_r;
    logic [WIDTH-1:0] lane_r [PACK-1];
    logic [FW-1:0]    frame_cnt_r;

    // FIFO storage, pointers and status.
    logic [DW:0]      mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic             valid_r;
    logic             overflow_r;
    logic [15:0]      drop_count_r;

    logic             word_done_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             last_s;
    logic [DW-1:0]    word_s;
    logic [AW:0]      level_next_s;
    logic [DW:0]      head_s;

    // Decide push/pop/drop for this edge and assemble the candidate word.
    always_comb begin
        word_done_s = enable & strobe & (lane_idx_r == IW'(PACK - 1));
        pop_s       = valid_r & m_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push_s      = word_done_s & ((level_r != LW'(DEPTH)) | pop_s);
        drop_s      = word_done_s & ~push_s;
        last_s      = (frame_cnt_r == FW'(FRAME_WORDS - 1));
        word_s      = {DW{1'b0}};
        for (int i = 0; i < PACK - 1; i++) begin
            word_s[i*WIDTH +: WIDTH] = lane_r[i];
        end
        word_s[(PACK-1)*WIDTH +: WIDTH] = sample;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Lane capture; disabling the block throws away any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_idx_r <= {IW{1'b0}};
            for (int i = 0; i < PACK - 1; i++) begin
                lane_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!enable) begin
            lane_idx_r <= {IW{1'b0}};
        end else if (strobe) begin
            if (word_done_s) begin
                lane_idx_r <= {IW{1'b0}};
            end else begin
                for (int i = 0; i < PACK - 1; i++) begin
                    if (lane_idx_r == IW'(i)) begin
                        lane_r[i] <= sample;
                    end
                end
                lane_idx_r <= lane_idx_r + IW'(1);
            end
        end
    end

    // Frame word counter; only accepted words advance it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= {FW{1'b0}};
        end else if (!enable) begin
            frame_cnt_r <= {FW{1'b0}};
        end else if (push_s) begin
            frame_cnt_r <= last_s ? {FW{1'b0}} : frame_cnt_r + FW'(1);
        end
    end

    // FIFO entry write: {last, data}.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {last_s, word_s};
        end
    end

    // FIFO pointers, occupancy and registered valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {LW{1'b0}};
            rd_ptr_r <= {LW{1'b0}};
            level_r  <= {LW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + LW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + LW'(1);
            end
            level_r <= level_next_s;
            valid_r <= (level_next_s != {LW{1'b0}});
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != 16'hFFFF) begin
                drop_count_r <= drop_count_r + 16'h0001;
            end
        end
    end

    // Present the FIFO head; zeros while nothing is valid.
    always_comb begin
        head_s = mem_r[rd_ptr_r[AW-1:0]];
        if (valid_r) begin
            m_data = head_s[DW-1:0];
            m_last = head_s[DW];
        end else begin
            m_data = {DW{1'b0}};
            m_last = 1'b0;
        end
    end

    assign m_valid    = valid_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;
    assign level      = level_r;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: a queue-based reference model predicts the
// stream, occupancy and loss statistics; directed scenarios add literal checks.
module tb_adc_sample_packer;

    localparam int W  = 16;
    localparam int P  = 2;
    localparam int D  = 16;
    localparam int FWD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [W-1:0]      sample;
    logic              strobe;
    logic [W*P-1:0]    m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              overflow;
    logic [15:0]       drop_count;
    logic [$clog2(D):0] level;

    adc_sample_packer #(.WIDTH(W), .PACK(P), .DEPTH(D), .FRAME_WORDS(FWD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample(sample), .strobe(strobe),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .overflow(overflow), .drop_count(drop_count), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [W*P:0]  mq[$];
    logic [W-1:0]  part[$];
    int            frame_n;
    int            drops;
    bit            ovf;

    // Words seen leaving the DUT.
    logic [W*P-1:0] got_data[$];
    bit             got_last[$];

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        part.delete();
        frame_n = 0;
        drops   = 0;
        ovf     = 1'b0;
    endtask

    task automatic check_all();
        logic [W*P:0] head;
        chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
        chk("level", 64'(level), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("drop_count", 64'(drop_count), 64'(drops));
        if (mq.size() != 0) begin
            head = mq[0];
            chk("m_data", 64'(m_data), 64'(head[W*P-1:0]));
            chk("m_last", 64'(m_last), 64'(head[W*P]));
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(input bit en, input bit st, input logic [W-1:0] smp, input bit rdy);
        logic [W*P-1:0] word;
        enable  = en;
        strobe  = st;
        sample  = smp;
        m_ready = rdy;
        if (m_valid && rdy) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
        end
        if (mq.size() != 0 && rdy) begin
            void'(mq.pop_front());
        end
        if (!en) begin
            part.delete();
            frame_n = 0;
        end else if (st) begin
            part.push_back(smp);
            if (part.size() == P) begin
                for (int i = 0; i < P; i++) begin
                    word[i*W +: W] = part[i];
                end
                part.delete();
                if (mq.size() < D) begin
                    mq.push_back({frame_n == FWD - 1, word});
                    frame_n = (frame_n + 1) % FWD;
                end else begin
                    ovf = 1'b1;
                    if (drops < 65535) drops++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        enable  = 1'b0;
        strobe  = 1'b0;
        m_ready = 1'b0;
        sample  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;
        got_data.delete();
        got_last.delete();
    endtask

    initial begin
        logic [13:0] mask;
        vectors     = 0;
        miscompares = 0;
        model_clear();

        // Reset held with clock and strobe toggling: everything stays zero.
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        sample  = 16'h1234;
        strobe  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe = i[0];
            sample = 16'(16'h1111 * i);
            @(posedge clk);
            #1;
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_m_data", 64'(m_data), 64'd0);
            chk("rst_m_last", 64'(m_last), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            chk("rst_drop_count", 64'(drop_count), 64'd0);
            chk("rst_level", 64'(level), 64'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("post_rst_m_data", 64'(m_data), 64'd0);

        // Basic packing and first-word latency.
        cycle(1'b1, 1'b1, 16'h0001, 1'b1);
        chk("pack_no_valid_yet", 64'(m_valid), 64'd0);
        cycle(1'b1, 1'b1, 16'h0002, 1'b1);
        chk("pack_valid", 64'(m_valid), 64'd1);
        chk("pack_word", 64'(m_data), 64'h0000_0000_0002_0001);
        chk("pack_level1", 64'(level), 64'd1);
        cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("pack_level0", 64'(level), 64'd0);

        // Back-pressure: 17 words into a 16-deep FIFO.
        apply_reset();
        for (int i = 1; i <= 34; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
        chk("bp_level", 64'(level), 64'd16);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_drop_count", 64'(drop_count), 64'd1);
        chk("bp_head", 64'(m_data), 64'h0000_0000_0002_0001);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("bp_drained_words", 64'(got_data.size()), 64'd16);
        if (got_data.size() == 16) chk("bp_last_word", 64'(got_data[15]), 64'h0000_0000_0020_001F);

        // Full FIFO with a pop on the completing edge: accepted, no loss.
        apply_reset();
        for (int i = 1; i <= 33; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
        chk("full_level", 64'(level), 64'd16);
        cycle(1'b1, 1'b1, 16'd34, 1'b1);
        chk("full_pop_level", 64'(level), 64'd16);
        chk("full_pop_overflow", 64'(overflow), 64'd0);
        chk("full_pop_drops", 64'(drop_count), 64'd0);
        chk("full_pop_head", 64'(m_data), 64'h0000_0000_0004_0003);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);

        // Frame markers, then restart after a one-cycle disable.
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 16'(16'h0100 + i), 1'b1);
            chk("stream_level_le1", 64'(level <= 1), 64'd1);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'(16'h0200 + i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("frame_words", 64'(got_last.size()), 64'd14);
        mask = '0;
        for (int i = 0; i < 14 && i < got_last.size(); i++) mask[i] = got_last[i];
        chk("frame_last_mask", 64'(mask), 64'h2088);

        // Partial word thrown away by disable; strobe while disabled ignored.
        apply_reset();
        cycle(1'b1, 1'b1, 16'hAAAA, 1'b1);
        cycle(1'b0, 1'b1, 16'hBBBB, 1'b1);
        cycle(1'b1, 1'b1, 16'h0003, 1'b1);
        cycle(1'b1, 1'b1, 16'h0004, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("partial_words", 64'(got_data.size()), 64'd1);
        if (got_data.size() == 1) chk("partial_word", 64'(got_data[0]), 64'h0000_0000_0004_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
